// File: rtl/mem_rd_pkg.sv
// Shared types and helpers for the stream reader of the register-array memory.
// Address wrap is an explicit compare so non-power-of-two depths visit each entry once.
package mem_rd_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FIN} rd_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 7;

  function automatic int unsigned next_addr(input int unsigned addr,
                                            input int unsigned depth = DEF_DEPTH);
    return (addr == depth - 1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/mem_regfile.sv
// DEPTH x WIDTH flop array: one write port, one clear port (write wins), and
// one combinational read port. Out-of-range addresses match no entry.
module mem_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_addr == AW'(i))
          mem[i] <= wr_data;
        else if (clr_en && clr_addr == AW'(i))
          mem[i] <= '0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == AW'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Sweeps count entries of the register array from start_addr (wrapping) and
// streams them on a valid/ready port, optionally clearing each entry as it is read.
module mem_stream_reader
  import mem_rd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [CW-1:0]    count,
  input  logic             clr_on_read,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rd_state_t        state;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    nxt;
  logic [AW-1:0]    rd_addr;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    sat_count;
  logic             clr_flag;
  logic             hs;
  logic [WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0] rd_word;

  assign nxt       = AW'(next_addr(32'(addr), DEPTH));
  assign rd_addr   = (state == LOAD) ? addr : nxt;
  assign hs        = (state == STREAM) && out_valid && out_ready;
  assign sat_count = (count > DEPTH_C) ? DEPTH_C : count;
  // A write landing on the entry being captured this cycle is forwarded.
  assign rd_word   = (wr_en && wr_addr == rd_addr) ? wr_data : mem_rd;

  mem_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_en   (hs && clr_flag),
    .clr_addr (out_addr),
    .rd_addr  (rd_addr),
    .rd_data  (mem_rd)
  );

  // Scan controller; done and err default low so they only pulse for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      clr_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ({1'b0, start_addr} >= DEPTH_A) begin
              err <= 1'b1;
            end else if (count == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              addr      <= start_addr;
              remaining <= sat_count;
              clr_flag  <= clr_on_read;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          out_data  <= rd_word;
          out_addr  <= addr;
          out_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            if (remaining > CW'(1)) begin
              addr      <= nxt;
              out_addr  <= nxt;
              out_data  <= rd_word;
              remaining <= remaining - CW'(1);
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed and randomized scans checked against an array model and a queue of
// expected beat addresses computed with modulo arithmetic.
module tb_mem_stream_reader;

  localparam int DEPTH = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic [2:0] start_addr = '0;
  logic [2:0] count = '0;
  logic       clr_on_read = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_addr;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] model [DEPTH];
  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mem_stream_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .start_addr  (start_addr),
    .count       (count),
    .clr_on_read (clr_on_read),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic writeEntry(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < DEPTH) model[a] = d;
  endtask

  // readyMode: 0 always ready, 1 alternate 1/0, 2 random.
  task automatic applyStimulus(input int sa, input int cnt, input bit clr,
                               input int readyMode, input int wrBeat,
                               input logic [7:0] wrVal, input bit pokeStart);
    int  expQ[$];
    int  eff;
    int  beatIdx;
    int  a;
    bit  doneSeen;
    bit  rdy;
    eff = (cnt > DEPTH) ? DEPTH : cnt;
    for (int k = 0; k < eff; k++) expQ.push_back((sa + k) % DEPTH);
    @(negedge clk);
    start       = 1'b1;
    start_addr  = 3'(sa);
    count       = 3'(cnt);
    clr_on_read = clr;
    out_ready   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("loadBusy", busy, 1);
    checkOutput("loadValid", out_valid, 0);
    doneSeen = 1'b0;
    beatIdx  = 0;
    for (int cyc = 0; cyc < 200 && !doneSeen; cyc++) begin
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (cyc == 0) checkOutput("firstValid", out_valid, 1);
      if (pokeStart && cyc == 2) begin
        start      = 1'b1;
        start_addr = 3'd3;
        count      = 3'd1;
      end
      if (done) begin
        doneSeen = 1'b1;
        checkOutput("doneBusy", busy, 0);
        checkOutput("doneValid", out_valid, 0);
        checkOutput("allBeatsSeen", expQ.size(), 0);
        if (readyMode == 0) checkOutput("fullThroughput", cyc, eff);
      end else if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("extraBeat", out_valid, 0);
        end else begin
          a = expQ[0];
          checkOutput("beatAddr", out_addr, a);
          checkOutput("beatData", out_data, model[a]);
          checkOutput("busyStream", busy, 1);
          if (rdy) begin
            void'(expQ.pop_front());
            if (clr) model[a] = 8'h00;
            if (beatIdx == wrBeat) begin
              wr_en   = 1'b1;
              wr_addr = 3'(a);
              wr_data = wrVal;
              model[a] = wrVal;
            end
            beatIdx++;
          end
        end
      end
    end
    out_ready = 1'b0;
    wr_en     = 1'b0;
    start     = 1'b0;
    checkOutput("scanDone", doneSeen, 1);
    @(negedge clk);
    checkOutput("donePulseOnce", done, 0);
    checkOutput("idleAfterScan", busy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    #2;
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstData", out_data, 0);
    checkOutput("rstAddr", out_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ramp pattern, full sweep at full throughput.
    for (int i = 0; i < DEPTH; i++) writeEntry(i, 8'(8'h10 + i));
    applyStimulus(0, 7, 1'b0, 0, -1, 8'h00, 1'b0);

    // Wrapping sweep.
    applyStimulus(5, 4, 1'b0, 0, -1, 8'h00, 1'b0);

    // Random contents, alternating stalls, then randomized scans.
    for (int i = 0; i < DEPTH; i++) writeEntry(i, 8'($urandom));
    applyStimulus($urandom_range(0, DEPTH - 1), 4, 1'b0, 1, -1, 8'h00, 1'b0);
    for (int n = 0; n < 5; n++)
      applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(1, 7), 1'b0, 2, -1,
                    8'h00, 1'b0);

    // Out-of-range write is dropped; start during a scan is ignored.
    writeEntry(7, 8'hEE);
    applyStimulus(1, 7, 1'b0, 2, -1, 8'h00, 1'b1);

    // Clear-on-read sweep with a same-cycle write on the fourth handshake.
    applyStimulus(2, 7, 1'b1, 0, 3, 8'hA5, 1'b0);
    applyStimulus(0, 7, 1'b0, 2, -1, 8'h00, 1'b0);

    // Bad start address.
    @(negedge clk);
    start = 1'b1; start_addr = 3'd7; count = 3'd3; clr_on_read = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("errPulse", err, 1);
    checkOutput("errBusy", busy, 0);
    checkOutput("errValid", out_valid, 0);
    @(negedge clk);
    checkOutput("errOnce", err, 0);
    checkOutput("errNoValid", out_valid, 0);
    checkOutput("errStayIdle", busy, 0);

    // Zero-length scan.
    @(negedge clk);
    start = 1'b1; start_addr = 3'd2; count = 3'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zeroDone", done, 1);
    checkOutput("zeroBusy", busy, 0);
    checkOutput("zeroValid", out_valid, 0);
    @(negedge clk);
    checkOutput("zeroDoneOnce", done, 0);
    checkOutput("zeroNoValid", out_valid, 0);

    // Reset in the middle of a stream.
    for (int i = 0; i < DEPTH; i++) writeEntry(i, 8'($urandom_range(1, 255)));
    @(negedge clk);
    start = 1'b1; start_addr = 3'd0; count = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midStreamValid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", out_valid, 0);
    checkOutput("asyncRstBusy", busy, 0);
    checkOutput("asyncRstDone", done, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("noDoneAfterRst", done, 0);
    rst_n = 1'b1;
    applyStimulus(0, 7, 1'b0, 0, -1, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
